set_bit_enumerator: RTL and testbench
=====================================

// Module: set_bit_enumerator
// PURPOSE
//   Expands a WIDTH-bit word into a stream of the indices of its set bits, lowest first, one per beat.
//   Complements the popcount path: the popcount collapses a word to its count of ones; this block
//   lists each one individually and reports a running count, closing with a last flag.
//   Sits between a word producer (valid/ready) and a serial index consumer (valid/ready).
// PARAMETERS
//   WIDTH  24  input word width; WIDTH >= 2
//   IDX_W  $clog2(WIDTH)    derived localparam; bit-index width
//   CNT_W  $clog2(WIDTH+1)  derived localparam; count width, holds WIDTH when all bits are set
// PORTS
//   clk_i        in   1      clock; all logic on posedge
//   rst_i        in   1      asynchronous, active-high reset
//   data_i       in   WIDTH  word to enumerate
//   data_val_i   in   1      data_i valid
//   data_ready_o out  1      block can accept a word
//   idx_o        out  IDX_W  index of current set bit
//   idx_cnt_o    out  CNT_W  ordinal of this beat (1..K); 0 on the empty-word beat
//   idx_last_o   out  1      final beat of the current word
//   idx_none_o   out  1      word had no set bits (single beat)
//   idx_val_o    out  1      output beat valid
//   idx_ready_i  in   1      consumer accepts the beat
// BEHAVIOUR
// - Reset, async assert and any cycle: state IDLE, data_ready_o=1, idx_val_o=0, idx_o=0,
//   idx_cnt_o=0, idx_last_o=0, idx_none_o=0, internal mask=0.
//   Reset during EMIT discards the rest of the word. No partial beat follows release.
// - FSM states IDLE and EMIT. data_ready_o = (state==IDLE) and is registered.
// - IDLE: accept on data_val_i & data_ready_o. At that edge:
//   mask <= data_i; state <= EMIT; first beat is loaded into the output registers.
//   The first beat is valid the cycle after acceptance (latency 1).
// - Beat load from mask m:
//   idx_o = index of the lowest set bit of m; idx_last_o = (m has exactly one bit set).
//   idx_cnt_o = previous count + 1, where the count restarts at 1 for each word.
// - Zero word: a single beat with idx_val_o=1, idx_none_o=1, idx_last_o=1, idx_o=0, idx_cnt_o=0.
// - EMIT, on handshake (idx_val_o & idx_ready_i):
//   - Clear the emitted bit from the mask.
//   - If the beat was not last, load the next beat at the same edge, so there are no bubbles.
//     K set bits take K cycles with idx_ready_i held high.
//   - If the beat was last: idx_val_o<=0, idx_last_o<=0, idx_none_o<=0, state<=IDLE,
//     data_ready_o<=1. This costs one idle cycle between words.
// - Backpressure: while idx_val_o=1 and idx_ready_i=0, idx_o, idx_cnt_o, idx_last_o and
//   idx_none_o are held stable. idx_val_o never drops without a handshake, except on reset.
// - data_val_i while data_ready_o=0 is ignored and the word is not consumed.
//   The producer must hold it until accepted.
// - data_i is sampled only at acceptance. Later changes to it have no effect on the current word.
// - Count width: idx_cnt_o reaches WIDTH for an all-ones word without overflow.
// - Every output is driven from a flop. There are no combinational in-to-out paths.
// TESTING
// 1. data_i=24'h000005, idx_ready_i=1 -> beats (idx 0,cnt 1,last 0), (idx 2,cnt 2,last 1);
//    data_ready_o is low for 2 cycles after acceptance.
// 2. data_i=24'h000000 -> one beat idx_none_o=1, idx_last_o=1, idx_cnt_o=0, idx_o=0;
//    data_ready_o=1 on the cycle after the handshake.
// 3. data_i=24'hFFFFFF, idx_ready_i=1 -> 24 consecutive beats idx 0..23, cnt 1..24,
//    idx_last_o only on idx 23.
// 4. data_i=24'h800001, idx_ready_i=0 for 3 cycles -> idx_o=0, cnt=1 held stable for 3 cycles;
//    then the beats idx 0 and idx 23 (last).
// 5. data_i=24'h00000F, assert rst_i after 2 beats -> outputs go to reset values immediately.
//    After release, data_i=24'h000010 -> single beat idx 4, cnt 1, last 1.
// 6. data_val_i=1 with a new word while in EMIT -> not accepted, data_ready_o=0.
//    It is accepted the cycle after the current last handshake, and its beats are correct.

Source files
------------

// File: rtl/set_bit_enumerator.sv
// rtl/set_bit_enumerator.sv - streams the indices of the set bits of a word, lowest first
//
// Purpose:
//   Accepts a WIDTH-bit word over a valid/ready handshake. It then emits one beat per set bit,
//   lowest index first. Each beat carries the bit index, its ordinal within the word, and a
//   last flag. A word with no set bits produces a single beat flagged with idx_none_o.
//
// Ports:
//   clk_i        in   1      clock, all logic on posedge
//   rst_i        in   1      asynchronous active-high reset
//   data_i       in   WIDTH  word to enumerate, sampled only at acceptance
//   data_val_i   in   1      data_i valid
//   data_ready_o out  1      block is idle and can accept a word (registered)
//   idx_o        out  IDX_W  index of the current set bit
//   idx_cnt_o    out  CNT_W  ordinal of this beat (1..K), 0 on the empty-word beat
//   idx_last_o   out  1      final beat of the current word
//   idx_none_o   out  1      word had no set bits
//   idx_val_o    out  1      output beat valid
//   idx_ready_i  in   1      consumer accepts the beat

module set_bit_enumerator #(
  parameter int WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         data_val_i,
  output logic                         data_ready_o,
  output logic [$clog2(WIDTH)-1:0]     idx_o,
  output logic [$clog2(WIDTH+1)-1:0]   idx_cnt_o,
  output logic                         idx_last_o,
  output logic                         idx_none_o,
  output logic                         idx_val_o,
  input  logic                         idx_ready_i
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mask_q;

  // Scan from the top down so the last hit is the lowest set bit.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // True when exactly one bit of m is set.
  function automatic logic single_bit(input logic [WIDTH-1:0] m);
    return (m != '0) && ((m & (m - WIDTH'(1))) == '0);
  endfunction

  logic [WIDTH-1:0] mask_rest;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_single;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_single;

  // m & (m-1) clears the lowest set bit, which is always the bit currently on idx_o.
  assign mask_rest  = mask_q & (mask_q - WIDTH'(1));
  assign acc_idx    = lowest_idx(data_i);
  assign acc_single = single_bit(data_i);
  assign nxt_idx    = lowest_idx(mask_rest);
  assign nxt_single = single_bit(mask_rest);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      data_ready_o <= 1'b1;
      idx_val_o    <= 1'b0;
      idx_o        <= '0;
      idx_cnt_o    <= '0;
      idx_last_o   <= 1'b0;
      idx_none_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_val_i && data_ready_o) begin
            mask_q       <= data_i;
            state_q      <= ST_EMIT;
            data_ready_o <= 1'b0;
            idx_val_o    <= 1'b1;
            if (data_i == '0) begin
              // Empty word: one marker beat, ordinal 0.
              idx_o      <= '0;
              idx_cnt_o  <= '0;
              idx_last_o <= 1'b1;
              idx_none_o <= 1'b1;
            end else begin
              idx_o      <= acc_idx;
              idx_cnt_o  <= CNT_W'(1);
              idx_last_o <= acc_single;
              idx_none_o <= 1'b0;
            end
          end
        end

        ST_EMIT: begin
          if (idx_val_o && idx_ready_i) begin
            mask_q <= mask_rest;
            if (idx_last_o) begin
              idx_val_o    <= 1'b0;
              idx_last_o   <= 1'b0;
              idx_none_o   <= 1'b0;
              state_q      <= ST_IDLE;
              data_ready_o <= 1'b1;
            end else begin
              // Load the following beat on the same edge, so there are no bubbles.
              idx_o      <= nxt_idx;
              idx_cnt_o  <= idx_cnt_o + CNT_W'(1);
              idx_last_o <= nxt_single;
            end
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          data_ready_o <= 1'b1;
          idx_val_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// tb/tb_set_bit_enumerator.sv - self-checking bench for set_bit_enumerator

module tb_set_bit_enumerator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [23:0] data_i;
  logic        data_val_i;
  logic        data_ready_o;
  logic [4:0]  idx_o;
  logic [4:0]  idx_cnt_o;
  logic        idx_last_o;
  logic        idx_none_o;
  logic        idx_val_o;
  logic        idx_ready_i;

  set_bit_enumerator #(.WIDTH(24)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .idx_o        (idx_o),
    .idx_cnt_o    (idx_cnt_o),
    .idx_last_o   (idx_last_o),
    .idx_none_o   (idx_none_o),
    .idx_val_o    (idx_val_o),
    .idx_ready_i  (idx_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic [4:0] cnt;
    logic       last;
    logic       none;
  } beat_t;

  typedef struct {
    logic [23:0] word;
    int          beats;
    int          first_idx;
    int          last_idx;
    int          busy;
  } vec_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    rdy_mode = 0;     // 0: always ready, 1: random, 2: driven by hand
  int    beats_seen = 0;
  int    first_idx_seen = 0;
  int    last_idx_seen = 0;
  int    last_hs_cyc = 0;
  logic  held = 1'b0;
  logic [11:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: list every set bit in ascending order with its ordinal.
  task automatic push_word(input logic [23:0] w);
    int    total;
    int    n;
    beat_t b;
    total = 0;
    for (int i = 0; i < 24; i++) total += w[i];
    if (total == 0) begin
      b.idx = 0; b.cnt = 0; b.last = 1'b1; b.none = 1'b1;
      exp_q.push_back(b);
    end else begin
      n = 0;
      for (int i = 0; i < 24; i++) begin
        if (w[i]) begin
          n++;
          b.idx = 5'(i); b.cnt = 5'(n); b.last = (n == total); b.none = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (rst_i) begin
      held = 1'b0;
    end else begin
      if (held)
        check("hold_stable", {idx_val_o, idx_o, idx_cnt_o, idx_none_o}, snap);
      if (idx_val_o && idx_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", idx_o, 32'hDEAD);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", {idx_o, idx_cnt_o, idx_last_o, idx_none_o},
                {e.idx, e.cnt, e.last, e.none});
        end
        beats_seen++;
        if (idx_cnt_o <= 1) first_idx_seen = idx_o;
        if (idx_last_o) begin
          last_idx_seen = idx_o;
          last_hs_cyc = cyc;
        end
      end
      held = idx_val_o && !idx_ready_i;
      snap = {idx_val_o, idx_o, idx_cnt_o, idx_none_o};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) idx_ready_i = 1'b1;
      else if (rdy_mode == 1) idx_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [23:0] w, output int acc_cyc, output int waited);
    int t;
    @(posedge clk);
    #1;
    data_i = w;
    data_val_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!data_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    acc_cyc = cyc;
    if (!data_ready_o) begin
      check("accept_timeout", 0, 1);
    end else begin
      push_word(w);
    end
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
    data_i = 24'($urandom);   // must not disturb the word already taken
  endtask

  task automatic wait_idle(output int busy);
    int b;
    b = 0;
    @(negedge clk);
    while (!data_ready_o && b < 100) begin
      b++;
      @(negedge clk);
    end
    busy = b;
  endtask

  vec_t tbl[6];
  int   acc, wt, busy, t;

  initial begin
    tbl[0] = '{24'h000005, 2,  0,  2,  2};
    tbl[1] = '{24'h000000, 1,  0,  0,  1};
    tbl[2] = '{24'hFFFFFF, 24, 0, 23, 24};
    tbl[3] = '{24'h800001, 2,  0, 23,  2};
    tbl[4] = '{24'h000010, 1,  4,  4,  1};
    tbl[5] = '{24'h400000, 1, 22, 22,  1};

    rst_i = 1'b1;
    data_i = '0;
    data_val_i = 1'b0;
    idx_ready_i = 1'b1;
    #3;
    check("rst_outputs", {data_ready_o, idx_val_o, idx_o, idx_cnt_o, idx_last_o, idx_none_o},
          {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Table-driven words with the consumer always ready.
    foreach (tbl[k]) begin
      beats_seen = 0;
      send_word(tbl[k].word, acc, wt);
      wait_idle(busy);
      check($sformatf("busy_%0h", tbl[k].word), busy, tbl[k].busy);
      check($sformatf("beats_%0h", tbl[k].word), beats_seen, tbl[k].beats);
      check($sformatf("first_%0h", tbl[k].word), first_idx_seen, tbl[k].first_idx);
      check($sformatf("last_%0h", tbl[k].word), last_idx_seen, tbl[k].last_idx);
    end

    // Backpressure: first beat held for three cycles.
    @(negedge clk);
    rdy_mode = 2;
    idx_ready_i = 1'b0;
    send_word(24'h800001, acc, wt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {idx_val_o, idx_o, idx_cnt_o, idx_last_o}, {1'b1, 5'd0, 5'd1, 1'b0});
    end
    @(posedge clk);
    #1;
    idx_ready_i = 1'b1;
    rdy_mode = 0;
    wait_idle(busy);
    check("bp_drained", exp_q.size(), 0);

    // Reset in the middle of a word.
    send_word(24'h00000F, acc, wt);
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1'b1;
    #1;
    check("mid_rst", {data_ready_o, idx_val_o, idx_o, idx_cnt_o, idx_last_o, idx_none_o},
          {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0});
    check("mid_rst_beats", beats_seen >= 2, 1);
    exp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    beats_seen = 0;
    send_word(24'h000010, acc, wt);
    wait_idle(busy);
    check("post_rst_beats", beats_seen, 1);
    check("post_rst_idx", last_idx_seen, 4);

    // A word offered during EMIT waits until right after the last handshake.
    send_word(24'h000005, acc, wt);
    send_word(24'h000300, acc, wt);
    check("held_off", wt > 0, 1);
    check("accept_after_last", acc, last_hs_cyc + 1);
    wait_idle(busy);

    // Randomised traffic against the model.
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [23:0] w;
      case ($urandom_range(0, 4))
        0: w = 24'h0;
        1: w = 24'hFFFFFF;
        2: w = 24'h1 << $urandom_range(0, 23);
        default: w = 24'($urandom);
      endcase
      send_word(w, acc, wt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    wait_idle(busy);
    check("final_idle", {data_ready_o, idx_val_o}, {1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
